// File: rtl/apb_gpio_bridge.sv
// apb_gpio_bridge: APB slave that shadows GPIO registers and issues queued, gap-spaced GPIO command bytes
//   clk, rst (async, active-low)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA -> PRDATA/PREADY/PSLVERR : APB slave port
//   GPIO_CMD : command byte to the GPIO ([7:6] target, [5:0] payload, 8'hC0 = no-op)
//   GPIO_W/GPIO_DATA : pin value report from the GPIO, captured into PIN
module apb_gpio_bridge #(
    parameter int CMD_DEPTH = 4,
    parameter int CMD_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  GPIO_CMD,
    input  logic        GPIO_W,
    input  logic [7:0]  GPIO_DATA
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = CMD_GAP > 1 ? $clog2(CMD_GAP) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(CMD_GAP > 0 ? CMD_GAP - 1 : 0);
    localparam logic [7:0] NOP = 8'hC0;

    typedef enum logic {IDLE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_d;
    logic [7:0]    mem [CMD_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          ctrl, valid;
    logic [5:0]    dir, port, pin;
    logic          access, is_ctrl, is_dir, is_port, is_pin, wr_ok, full, empty, push, pop;
    logic [7:0]    cmd_in;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign unused_bits = ^{PWDATA[31:6], GPIO_DATA[7:6]};

    assign access  = PSEL & PENABLE;
    assign is_ctrl = PADDR == 4'h0;
    assign is_dir  = PADDR == 4'h4;
    assign is_port = PADDR == 4'h8;
    assign is_pin  = PADDR == 4'hC;
    assign wr_ok   = is_ctrl | is_dir | is_port;
    assign full    = count == (AW+1)'(CMD_DEPTH);
    assign empty   = count == '0;
    // The stall is driven by the registered count, so a pop in the same
    // cycle cannot release it; the push waits for the next PREADY=1 edge.
    assign push    = access & PWRITE & wr_ok & !full;
    assign PREADY  = !(access & PWRITE & wr_ok & full);
    assign PSLVERR = access & (PWRITE ? !wr_ok : !(wr_ok | is_pin));
    assign cmd_in  = is_ctrl ? {7'b0, PWDATA[0]} : {is_port ? 2'b10 : 2'b01, PWDATA[5:0]};
    assign rd_mux  = is_ctrl ? {31'b0, ctrl} :
                     is_dir  ? {26'b0, dir}  :
                     is_port ? {26'b0, port} :
                     is_pin  ? {24'b0, valid, 1'b0, pin} : 32'b0;
    assign PRDATA  = (access & !PWRITE) ? rd_mux : 32'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = NOP;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                cmd_d   = mem[rptr];
                pop     = 1'b1;
                cnt_d   = '0;
                state_d = CMD_GAP > 0 ? GAP : IDLE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            GPIO_CMD <= NOP;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            GPIO_CMD <= cmd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ctrl  <= 1'b0;
            dir   <= '0;
            port  <= '0;
            pin   <= '0;
            valid <= 1'b0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push && is_ctrl) begin
                ctrl <= PWDATA[0];
                // UART mode in the GPIO forces its DIR; mirror that here.
                if (PWDATA[0]) dir <= 6'b000010;
            end
            if (push && is_dir) dir <= PWDATA[5:0];
            if (push && is_port) port <= PWDATA[5:0];
            if (GPIO_W) begin
                pin   <= GPIO_DATA[5:0];
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_gpio_bridge.sv
// tb_apb_gpio_bridge: table-driven, directed and random checks of apb_gpio_bridge against a timing-level model
module tb_apb_gpio_bridge;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic        clk = 0, rst = 1;
    logic        PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [3:0]  PADDR = 0;
    logic [31:0] PWDATA = 0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  GPIO_CMD;
    logic        GPIO_W = 0;
    logic [7:0]  GPIO_DATA = 0;

    apb_gpio_bridge #(.CMD_DEPTH(DEPTH), .CMD_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .GPIO_CMD(GPIO_CMD), .GPIO_W(GPIO_W), .GPIO_DATA(GPIO_DATA)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    // Commands accepted but not yet seen on GPIO_CMD, with the edge they must appear at.
    logic [7:0] q_cmd[$];
    int         q_edge[$];
    int         last_issue = -100;
    logic       m_ctrl = 0, m_valid = 0;
    logic [5:0] m_dir = 0, m_port = 0, m_pin = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        err;
    } vec_t;
    vec_t tbl[20];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic mapped_rw(logic [3:0] a);
        return a == 4'h0 || a == 4'h4 || a == 4'h8;
    endfunction

    function automatic logic [31:0] model_rd(logic [3:0] a);
        case (a)
            4'h0: return {31'b0, m_ctrl};
            4'h4: return {26'b0, m_dir};
            4'h8: return {26'b0, m_port};
            4'hC: return {24'b0, m_valid, 1'b0, m_pin};
            default: return 32'b0;
        endcase
    endfunction

    task automatic m_reset();
        q_cmd.delete();
        q_edge.delete();
        last_issue = -100;
        m_ctrl = 0; m_dir = 0; m_port = 0; m_pin = 0; m_valid = 0;
    endtask

    // Accept at the coming edge A: the command may appear at A+1 at the earliest,
    // and no sooner than GAP no-op cycles after the previous command.
    task automatic accept(input logic [3:0] a, input logic [31:0] d);
        logic [7:0] c;
        int e;
        c = (a == 4'h0) ? {7'b0, d[0]} : (a == 4'h4) ? {2'b01, d[5:0]} : {2'b10, d[5:0]};
        e = cyc + 2;
        if (last_issue + GAP + 1 > e) e = last_issue + GAP + 1;
        last_issue = e;
        q_cmd.push_back(c);
        q_edge.push_back(e);
        if (a == 4'h0) begin
            m_ctrl = d[0];
            if (d[0]) m_dir = 6'b000010;
        end
        if (a == 4'h4) m_dir = d[5:0];
        if (a == 4'h8) m_port = d[5:0];
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst && GPIO_W) begin
            m_pin = GPIO_DATA[5:0];
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        e = 8'hC0;
        if (rst && q_edge.size() > 0 && q_edge[0] == cyc) begin
            e = q_cmd.pop_front();
            void'(q_edge.pop_front());
        end
        check("gpio_cmd", 32'(GPIO_CMD), 32'(e));
    end

    // All bus tasks start and end at posedge+#1, so calls chain back-to-back.
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic exp_err);
        logic exp_rdy;
        int n;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge clk); #1;
        PENABLE = 1;
        n = 0;
        forever begin
            @(negedge clk); #1;
            exp_rdy = exp_err || (q_cmd.size() < DEPTH);
            check("pready_wr", 32'(PREADY), 32'(exp_rdy));
            check("pslverr_wr", 32'(PSLVERR), 32'(exp_err));
            check("prdata_wr", PRDATA, 32'b0);
            if (PREADY) break;
            if (++n > 100) begin
                checks++;
                failures++;
                $display("FAIL pready_timeout: got PREADY=0 for %0d cycles expected release", n);
                break;
            end
        end
        if (!exp_err && PREADY) accept(a, d);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic apb_read(input logic [3:0] a, input logic [31:0] exp, input logic exp_err, input string name);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(negedge clk); #1;
        check("prdata_setup", PRDATA, 32'b0);
        @(posedge clk); #1;
        PENABLE = 1;
        @(negedge clk); #1;
        check(name, PRDATA, exp);
        check("pslverr_rd", 32'(PSLVERR), 32'(exp_err));
        check("pready_rd", 32'(PREADY), 32'd1);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q_cmd.size() > 0; i++) @(posedge clk);
        repeat (GAP + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0, 4'h0, 0, 32'h00, 0};
        tbl[1]  = '{0, 4'h4, 0, 32'h00, 0};
        tbl[2]  = '{0, 4'h8, 0, 32'h00, 0};
        tbl[3]  = '{0, 4'hC, 0, 32'h00, 0};
        tbl[4]  = '{1, 4'h4, 32'h2A, 0, 0};
        tbl[5]  = '{0, 4'h4, 0, 32'h2A, 0};
        tbl[6]  = '{1, 4'h0, 32'h1, 0, 0};
        tbl[7]  = '{0, 4'h0, 0, 32'h01, 0};
        tbl[8]  = '{0, 4'h4, 0, 32'h02, 0};
        tbl[9]  = '{1, 4'hC, 32'h5, 0, 1};
        tbl[10] = '{1, 4'h3, 32'h7, 0, 1};
        tbl[11] = '{0, 4'h3, 0, 32'h00, 1};
        tbl[12] = '{0, 4'hE, 0, 32'h00, 1};
        tbl[13] = '{1, 4'h8, 32'hFFFFFFC1, 0, 0};
        tbl[14] = '{0, 4'h8, 0, 32'h01, 0};
        tbl[15] = '{1, 4'h0, 32'h0, 0, 0};
        tbl[16] = '{0, 4'h4, 0, 32'h02, 0};
        tbl[17] = '{0, 4'h0, 0, 32'h00, 0};
        tbl[18] = '{1, 4'h4, 32'h15, 0, 0};
        tbl[19] = '{0, 4'h4, 0, 32'h15, 0};

        #1 rst = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1;

        foreach (tbl[i]) begin
            if (tbl[i].wr) apb_write(tbl[i].a, tbl[i].d, tbl[i].err);
            else apb_read(tbl[i].a, tbl[i].exp, tbl[i].err, $sformatf("tbl_rd%0d", i));
        end
        drain();

        GPIO_W = 1; GPIO_DATA = 8'h15;
        @(posedge clk); #1;
        GPIO_W = 0;
        apb_read(4'hC, 32'h95, 0, "pin_capture");
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 4'hC;
        @(posedge clk); #1;
        PENABLE = 1; GPIO_W = 1; GPIO_DATA = 8'h2A;
        @(negedge clk); #1;
        check("pin_same_cycle", PRDATA, 32'h95);
        @(posedge clk); #1;
        GPIO_W = 0; PSEL = 0; PENABLE = 0;
        apb_read(4'hC, 32'hAA, 0, "pin_next_cycle");

        for (int i = 1; i <= 12; i++) apb_write(4'h8, 32'(i), 0);
        drain();

        for (int i = 0; i < 40 && q_cmd.size() < 3; i++) apb_write(4'h4, 32'(i + 8), 0);
        @(negedge clk); #2;
        rst = 0;
        m_reset();
        #1;
        check("rst_gpio_cmd", 32'(GPIO_CMD), 32'hC0);
        check("rst_pready", 32'(PREADY), 32'd1);
        check("rst_prdata", PRDATA, 32'b0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        repeat (20) @(posedge clk);
        #1;
        apb_read(4'h0, 32'h0, 0, "rst_ctrl");
        apb_read(4'h4, 32'h0, 0, "rst_dir");
        apb_read(4'h8, 32'h0, 0, "rst_port");
        apb_read(4'hC, 32'h0, 0, "rst_pin");

        for (int i = 0; i < 250; i++) begin
            int op, k;
            logic [3:0] a;
            op = $urandom_range(0, 9);
            k = $urandom_range(0, 5);
            a = (k < 4) ? 4'(k * 4) : 4'($urandom);
            if (op < 2) begin
                GPIO_W = 1; GPIO_DATA = 8'($urandom);
                @(posedge clk); #1;
                GPIO_W = 0;
            end else if (op < 6) begin
                apb_write(a, $urandom, !mapped_rw(a));
            end else begin
                apb_read(a, model_rd(a), !(mapped_rw(a) || a == 4'hC), "rand_rd");
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
